spi_txn_sequencer: RTL

Host-side transaction sequencer that sits directly upstream of the single-chip-select SPI master. It buffers outgoing bytes in a small TX FIFO and, on a start command, issues a fixed-length multi-byte transaction to the master using its `i_TX_Count`/`i_TX_DV`/`o_TX_Ready` handshake. It also re-times and indexes the returned MISO bytes, and reports completion or command errors to the host.

---
 rtl/spi_txn_sequencer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/spi_txn_sequencer.sv
// spi_txn_sequencer: buffers host TX bytes and issues fixed-length
// SPI master transactions, re-timing and indexing the returned bytes.
module spi_txn_sequencer #(
    parameter int MAX_BYTES_PER_CS = 2,
    parameter int FIFO_DEPTH       = 4,
    localparam int CW = $clog2(MAX_BYTES_PER_CS + 1),
    localparam int LW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          i_Clk,
    input  logic          i_Rst,
    input  logic          i_Wr_DV,
    input  logic [7:0]    i_Wr_Byte,
    output logic          o_Wr_Full,
    output logic [LW-1:0] o_Level,
    input  logic          i_Start,
    input  logic [CW-1:0] i_Len,
    output logic          o_Busy,
    output logic          o_Done,
    output logic          o_Err,
    output logic          o_RX_DV,
    output logic [7:0]    o_RX_Byte,
    output logic [CW-1:0] o_RX_Index,
    output logic [CW-1:0] o_TX_Count,
    output logic [7:0]    o_TX_Byte,
    output logic          o_TX_DV,
    input  logic          i_TX_Ready,
    input  logic          i_RX_DV,
    input  logic [7:0]    i_RX_Byte
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_RX
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [LW-1:0] r_level;
    logic [CW-1:0] r_len;
    logic [CW-1:0] r_issued;
    logic [CW-1:0] r_rx_cnt;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic          r_rx_dv;
    logic [7:0]    r_rx_byte;
    logic [CW-1:0] r_rx_index;
    logic          r_tx_dv;
    logic [7:0]    r_tx_byte;

    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_len_ok;
    logic          w_accept;
    logic          w_reject;
    logic          w_issue;
    logic          w_rx_take;
    logic          w_rx_all;
    logic [CW-1:0] w_rx_cnt_inc;

    assign w_full       = (r_level == LW'(FIFO_DEPTH));
    assign w_push       = i_Wr_DV && !w_full;
    assign w_pop        = r_tx_dv;
    assign w_rx_take    = i_RX_DV && (r_state != S_IDLE);
    assign w_rx_all     = (r_rx_cnt == r_len);
    assign w_rx_cnt_inc = r_rx_cnt + 1'b1;
    assign w_len_ok     = (i_Len != '0)
                       && (i_Len <= CW'(MAX_BYTES_PER_CS))
                       && (r_level >= LW'(i_Len));

    // State register
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next state, start decode and issue strobe
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_reject = 1'b0;
        w_issue  = 1'b0;
        if (i_Start) begin
            if (r_state == S_IDLE && w_len_ok) w_accept = 1'b1;
            else                               w_reject = 1'b1;
        end
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_ISSUE;
            end
            S_ISSUE: begin
                if (i_TX_Ready) begin
                    w_issue = 1'b1;
                    w_next  = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                // final byte can come back before the master's CS gap ends
                if (w_rx_all)
                    w_next = S_IDLE;
                else if (!i_TX_Ready && !r_tx_dv)
                    w_next = (r_issued < r_len) ? S_ISSUE : S_WAIT_RX;
            end
            S_WAIT_RX: begin
                if (w_rx_all) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // FIFO storage, left unreset: contents are gated by the level counter
    always_ff @(posedge i_Clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_Wr_Byte;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Transaction counters, master strobe and host status pulses
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_len      <= '0;
            r_issued   <= '0;
            r_rx_cnt   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_rx_dv    <= 1'b0;
            r_rx_byte  <= '0;
            r_rx_index <= '0;
            r_tx_dv    <= 1'b0;
            r_tx_byte  <= '0;
        end else begin
            r_tx_dv <= w_issue;
            r_err   <= w_reject;
            r_rx_dv <= w_rx_take;
            r_done  <= w_rx_take && (w_rx_cnt_inc == r_len);
            if (w_issue) begin
                r_tx_byte <= r_mem[r_rd_ptr];
                r_issued  <= r_issued + 1'b1;
            end
            if (w_rx_take) begin
                r_rx_byte  <= i_RX_Byte;
                r_rx_index <= r_rx_cnt;
                r_rx_cnt   <= w_rx_cnt_inc;
            end
            if (w_accept) begin
                r_len    <= i_Len;
                r_issued <= '0;
                r_rx_cnt <= '0;
                r_busy   <= 1'b1;
            end else if (r_done) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_Wr_Full  = w_full;
    assign o_Level    = r_level;
    assign o_Busy     = r_busy;
    assign o_Done     = r_done;
    assign o_Err      = r_err;
    assign o_RX_DV    = r_rx_dv;
    assign o_RX_Byte  = r_rx_byte;
    assign o_RX_Index = r_rx_index;
    assign o_TX_Count = r_len;
    assign o_TX_Byte  = r_tx_byte;
    assign o_TX_DV    = r_tx_dv;

endmodule
